// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: clock-enable divider, h/v counters and registered sync/bright decode.
// Optional `VGA_FRAME_TICK_EN adds a one-clk frame_tick pulse at the first pixel after the visible area.
module vga_sync_gen #(
   parameter int CLK_DIV = 4,
   parameter int H_TOTAL = 800,
   parameter int H_SYNC  = 96,
   parameter int H_START = 144,
   parameter int H_END   = 784,
   parameter int V_TOTAL = 525,
   parameter int V_SYNC  = 2,
   parameter int V_START = 35,
   parameter int V_END   = 515
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       pix_tick,
   output logic [9:0] hCount,
   output logic [9:0] vCount,
   output logic       hSync,
   output logic       vSync,
   output logic       bright
`ifdef VGA_FRAME_TICK_EN
   ,
   output logic       frame_tick
`endif
);

   localparam int              DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]      H_MAX   = 10'(H_TOTAL - 1);
   localparam logic [9:0]      V_MAX   = 10'(V_TOTAL - 1);
   localparam logic [9:0]      H_SYNC_C  = 10'(H_SYNC);
   localparam logic [9:0]      H_START_C = 10'(H_START);
   localparam logic [9:0]      H_END_C   = 10'(H_END);
   localparam logic [9:0]      V_SYNC_C  = 10'(V_SYNC);
   localparam logic [9:0]      V_START_C = 10'(V_START);
   localparam logic [9:0]      V_END_C   = 10'(V_END);
   localparam logic [9:0]      V_LAST_C  = 10'(V_END - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             step;
   logic             pix_tick_q;
   logic [9:0]       hcnt_q, hcnt_d;
   logic [9:0]       vcnt_q, vcnt_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             bright_q, bright_d;

   // Decode works on the next counter values so sync/bright line up with the counts they accompany.
   always_comb begin
      step   = (div_q == DIV_MAX);
      div_d  = step ? '0 : div_q + 1'b1;
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (step) begin
         if (hcnt_q == H_MAX) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_MAX) ? '0 : vcnt_q + 10'd1;
         end else begin
            hcnt_d = hcnt_q + 10'd1;
         end
      end
      hsync_d  = (hcnt_d >= H_SYNC_C);
      vsync_d  = (vcnt_d >= V_SYNC_C);
      bright_d = (hcnt_d >= H_START_C) && (hcnt_d < H_END_C) &&
                 (vcnt_d >= V_START_C) && (vcnt_d < V_END_C);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q      <= '0;
         pix_tick_q <= 1'b0;
         hcnt_q     <= '0;
         vcnt_q     <= '0;
         hsync_q    <= 1'b0;
         vsync_q    <= 1'b0;
         bright_q   <= 1'b0;
      end else begin
         div_q      <= div_d;
         pix_tick_q <= step;
         hcnt_q     <= hcnt_d;
         vcnt_q     <= vcnt_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         bright_q   <= bright_d;
      end
   end

   assign pix_tick = pix_tick_q;
   assign hCount   = hcnt_q;
   assign vCount   = vcnt_q;
   assign hSync    = hsync_q;
   assign vSync    = vsync_q;
   assign bright   = bright_q;

`ifdef VGA_FRAME_TICK_EN
   logic frame_tick_q, frame_tick_d;

   always_comb begin
      frame_tick_d = step && (hcnt_d == H_END_C) && (vcnt_d == V_LAST_C);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_tick_q <= 1'b0;
      end else begin
         frame_tick_q <= frame_tick_d;
      end
   end

   assign frame_tick = frame_tick_q;
`endif

endmodule
